// File: rtl/k005297_pkg.sv
// rtl/k005297_pkg.sv - command encodings, status bit map and state codes for the k005297 command register
`timescale 1ns/1ps
package k005297_pkg;

    // Command byte, bits [1:0]
    localparam logic [1:0] CMD_ABORT   = 2'b00;
    localparam logic [1:0] CMD_READ    = 2'b01;
    localparam logic [1:0] CMD_WRITE   = 2'b10;
    localparam logic [1:0] CMD_ILLEGAL = 2'b11;
    localparam int         CMD_IRQ_EN_BIT = 7;

    // Status byte bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_RDREQ    = 1;
    localparam int STAT_WRREQ    = 2;
    localparam int STAT_DONE     = 3;
    localparam int STAT_OVERRUN  = 4;
    localparam int STAT_ERROR    = 5;
    localparam int STAT_SYS_ERR  = 6;
    localparam int STAT_IRQ_PEND = 7;

    // Command register states
    typedef logic [2:0] cmdreg_state_t;
    localparam cmdreg_state_t ST_IDLE = 3'd0;
    localparam cmdreg_state_t ST_ARM  = 3'd1;
    localparam cmdreg_state_t ST_PEND = 3'd2;
    localparam cmdreg_state_t ST_ACPT = 3'd3;
    localparam cmdreg_state_t ST_ERR  = 3'd4;

    // Sticky status flags that clear when the CPU finishes a read
    typedef struct packed {
        logic error;
        logic overrun;
        logic done;
    } cmdreg_flags_t;

    function automatic logic is_page_cmd(input logic [1:0] code);
        return (code == CMD_READ) || (code == CMD_WRITE);
    endfunction

endpackage

// File: rtl/k005297_cmdreg_sync.sv
// rtl/k005297_cmdreg_sync.sv - multi-stage synchronizer for an active-low CPU strobe with edge pulses
`timescale 1ns/1ps
module k005297_cmdreg_sync #(
    parameter int STAGES = 2
) (
    input  logic i_MCLK,
    input  logic i_RST_n,
    input  logic i_strobe_n,
    output logic o_level_n,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw strobe through the synchronizer; keep one extra flop for edge detection
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_strobe_n};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_level_n = sync_q[STAGES-1];
    assign o_rise    = sync_q[STAGES-1] & ~prev_q;
    assign o_fall    = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/k005297_cmdreg.sv
// rtl/k005297_cmdreg.sv - CPU command/status register feeding the bubble FSM; IRQ output under K005297_CMDREG_IRQ_EN
`timescale 1ns/1ps
module k005297_cmdreg
    import k005297_pkg::*;
#(
    parameter int DBUS_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_MCLK,
    input  logic              i_RST_n,
    input  logic              i_CLK2M_PCEN_n,
    input  logic [19:0]       i_ROT20_n,
    input  logic              i_CS_n,
    input  logic              i_WR_n,
    input  logic              i_RD_n,
    input  logic              i_AB,
    input  logic [DBUS_W-1:0] i_DB,
    output logic [DBUS_W-1:0] o_DB,
    output logic              o_DB_OE,
    output logic              o_CMDREG_RDREQ,
    output logic              o_CMDREG_WRREQ,
    input  logic              i_CMDREG_RST_n,
    input  logic              i_FSMERR_RESTART_n,
    input  logic              i_CMD_ACCEPTED_n,
    input  logic              i_SYS_ERR_FLAG,
    output logic              o_BUSY,
    output logic              o_IRQ_n
);

    logic wr_level_n, wr_rise, wr_fall;
    logic rd_level_n, rd_rise, rd_fall;

    k005297_cmdreg_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
        .i_MCLK     (i_MCLK),
        .i_RST_n    (i_RST_n),
        .i_strobe_n (i_CS_n | i_WR_n),
        .o_level_n  (wr_level_n),
        .o_rise     (wr_rise),
        .o_fall     (wr_fall)
    );

    k005297_cmdreg_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
        .i_MCLK     (i_MCLK),
        .i_RST_n    (i_RST_n),
        .i_strobe_n (i_CS_n | i_RD_n),
        .o_level_n  (rd_level_n),
        .o_rise     (rd_rise),
        .o_fall     (rd_fall)
    );

    // Only the PLA sample slot of the phase ring matters here
    logic unused_rot;
    assign unused_rot = ^{i_ROT20_n[19:10], i_ROT20_n[8:0]};

    logic [DBUS_W-1:0] wr_data_q;
    logic [DBUS_W-1:0] cmd_q;
    logic              wr_ab_q;
    logic              rd_ab_q;
    cmdreg_state_t     state_q, state_d;
    logic              kind_rd_q, kind_rd_d;
    logic              rdreq_q, rdreq_d;
    logic              wrreq_q, wrreq_d;
    cmdreg_flags_t     flags_q, flags_set;
    logic [DBUS_W-1:0] db_q;
    logic              oe_q;
    logic              irq_pend;
    logic [DBUS_W-1:0] status_w;

    // Register select is taken at the start of an access; data follows the bus until the strobe ends
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            wr_data_q <= '0;
            wr_ab_q   <= 1'b0;
            rd_ab_q   <= 1'b0;
        end else begin
            if (!wr_level_n) wr_data_q <= i_DB;
            if (wr_fall)     wr_ab_q   <= i_AB;
            if (rd_fall)     rd_ab_q   <= i_AB;
        end
    end

    logic [1:0] cmd_code;
    logic       commit, cmd_rw, cmd_abort, cmd_ill;
    logic       fsm_en, ev_err, ev_acc, ev_done, pla_free, status_rd;

    assign commit    = wr_rise & wr_ab_q;
    assign cmd_code  = wr_data_q[1:0];
    assign cmd_rw    = commit & is_page_cmd(cmd_code);
    assign cmd_abort = commit & (cmd_code == CMD_ABORT);
    assign cmd_ill   = commit & (cmd_code == CMD_ILLEGAL);

    assign fsm_en    = ~i_CLK2M_PCEN_n;
    assign ev_err    = fsm_en & ~i_FSMERR_RESTART_n;
    assign ev_acc    = fsm_en & ~i_CMD_ACCEPTED_n;
    assign ev_done   = fsm_en & ~i_CMDREG_RST_n;
    assign pla_free  = fsm_en & i_ROT20_n[9];
    assign status_rd = rd_rise & ~rd_ab_q;

    // Next-state: FSM error restart dominates; CPU commits act at once, FSM strobes only on the 2MHz enable
    always_comb begin
        state_d           = state_q;
        kind_rd_d         = kind_rd_q;
        rdreq_d           = rdreq_q;
        wrreq_d           = wrreq_q;
        flags_set         = '0;
        flags_set.overrun = cmd_ill | (cmd_rw & (state_q != ST_IDLE));
        if (ev_err) begin
            state_d         = ST_ERR;
            rdreq_d         = 1'b0;
            wrreq_d         = 1'b0;
            flags_set.error = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_rw) begin
                        state_d   = ST_ARM;
                        kind_rd_d = (cmd_code == CMD_READ);
                    end
                end
                ST_ARM: begin
                    if (cmd_abort) begin
                        state_d = ST_IDLE;
                    end else if (pla_free) begin
                        state_d = ST_PEND;
                        rdreq_d = kind_rd_q;
                        wrreq_d = ~kind_rd_q;
                    end
                end
                ST_PEND: begin
                    if (cmd_abort) begin
                        state_d = ST_IDLE;
                        rdreq_d = 1'b0;
                        wrreq_d = 1'b0;
                    end else if (ev_acc) begin
                        state_d = ST_ACPT;
                    end
                end
                ST_ACPT: begin
                    if (ev_done) begin
                        state_d        = ST_IDLE;
                        rdreq_d        = 1'b0;
                        wrreq_d        = 1'b0;
                        flags_set.done = 1'b1;
                    end
                end
                ST_ERR: begin
                    if (cmd_abort || status_rd) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    rdreq_d = 1'b0;
                    wrreq_d = 1'b0;
                end
            endcase
        end
    end

    // State, request outputs and the last command byte
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q   <= ST_IDLE;
            kind_rd_q <= 1'b0;
            rdreq_q   <= 1'b0;
            wrreq_q   <= 1'b0;
            cmd_q     <= '0;
        end else begin
            state_q   <= state_d;
            kind_rd_q <= kind_rd_d;
            rdreq_q   <= rdreq_d;
            wrreq_q   <= wrreq_d;
            if (commit) cmd_q <= wr_data_q;
        end
    end

    // Sticky flags: a new event in the same cycle as the read-end clear keeps the flag set
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            flags_q <= '0;
        end else begin
            flags_q.done    <= flags_set.done    | (flags_q.done    & ~rd_rise);
            flags_q.overrun <= flags_set.overrun | (flags_q.overrun & ~rd_rise);
            flags_q.error   <= flags_set.error   | (flags_q.error   & ~rd_rise);
        end
    end

`ifdef K005297_CMDREG_IRQ_EN
    logic irq_n_q;

    assign irq_pend = (flags_q.done | flags_q.error) & cmd_q[CMD_IRQ_EN_BIT];

    // Registered interrupt line
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) irq_n_q <= 1'b1;
        else          irq_n_q <= ~irq_pend;
    end

    assign o_IRQ_n = irq_n_q;
`else
    assign irq_pend = 1'b0;
    assign o_IRQ_n  = 1'b1;
`endif

    always_comb begin
        status_w                = '0;
        status_w[STAT_BUSY]     = (state_q != ST_IDLE);
        status_w[STAT_RDREQ]    = rdreq_q;
        status_w[STAT_WRREQ]    = wrreq_q;
        status_w[STAT_DONE]     = flags_q.done;
        status_w[STAT_OVERRUN]  = flags_q.overrun;
        status_w[STAT_ERROR]    = flags_q.error;
        status_w[STAT_SYS_ERR]  = i_SYS_ERR_FLAG;
        status_w[STAT_IRQ_PEND] = irq_pend;
    end

    // Read port: drive while the synchronized read strobe is low, idle at zero otherwise
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            db_q <= '0;
            oe_q <= 1'b0;
        end else if (!rd_level_n) begin
            db_q <= i_AB ? cmd_q : status_w;
            oe_q <= 1'b1;
        end else begin
            db_q <= '0;
            oe_q <= 1'b0;
        end
    end

    assign o_DB           = db_q;
    assign o_DB_OE        = oe_q;
    assign o_CMDREG_RDREQ = rdreq_q;
    assign o_CMDREG_WRREQ = wrreq_q;
    assign o_BUSY         = (state_q != ST_IDLE);

endmodule
